// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit ripple slice is time-shared across NIBBLES slices, one per clock.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN.

module top_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] slice_a, slice_b, slice_sum;
  logic       slice_cout;

  assign slice_a = a_q[4*idx_q +: 4];
  assign slice_b = b_q[4*idx_q +: 4];

  top_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: invert B and inject the +1 through the carry.
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[4*idx_q +: 4] = slice_sum;
        carry_d             = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized self-checking bench for nibble_serial_adder_ctrl against an arithmetic reference model.
`timescale 1ns/1ps

module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {cout,sum} straight from the arithmetic definition
  function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                       input logic tcin, input logic tsub);
    logic [W-1:0] bb;
    logic         cc;
    bb = tb;
    cc = tcin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    if (tsub) begin
      bb = ~tb;
      cc = 1'b1;
    end
`else
    if (tsub) cc = tcin;
`endif
    return {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, cc};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic tsub, input bit disturb);
    logic [W:0] e;
    int         bcnt;
    e = model(ta, tb, tcin, tsub);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_after_start", 64'(done), 64'd0);
    bcnt = 1;
    for (int i = 1; i <= N; i++) begin
      start = (disturb && i == 1);
      if (disturb && i == 1) begin
        a = 16'hAAAA; b = 16'h5555;
      end
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (i < N) chk("done_early", 64'(done), 64'd0);
      else begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("sum", 64'(sum), 64'(e[W-1:0]));
        chk("cout", 64'(cout), 64'(e[W]));
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_cleared", 64'(done), 64'd0);
    chk("busy_cleared", 64'(busy), 64'd0);
    chk("sum_held", 64'(sum), 64'(e[W-1:0]));
    chk("cout_held", 64'(cout), 64'(e[W]));
    chk("busy_cycles", 64'(bcnt), 64'(N + 1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0);
    // Busy-time start is ignored; the back-to-back call lands in the first IDLE cycle
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    run_op(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0);

    // Asynchronous abort in the second ADD cycle
    @(negedge clk);
    start = 1'b1; a = 16'h7777; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done), 64'd0);
    end
    run_op(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
`endif

    for (int k = 0; k < 24; k++) begin
      logic ts;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), ts, bit'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
